data_plane_param: RTL and testbench
===================================

// Module: data_plane_param
// PURPOSE
//  Parametrised, handshaked successor of the single-channel data plane. Sits between the
//  photonic link interface and the GPP. RX: filters link packets by node ID, buffers
//  one message, hands it to the GPP word by word. TX: buffers one GPP message,
//  streams it as packets under link backpressure. RX and TX run independently.
// PARAMETERS
//  DATA_W    16  payload width (GPP word)
//  ID_W      16  node ID width; packet = {dest_id[ID_W-1:0], payload[DATA_W-1:0]}
//  RX_DEPTH  16  RX buffer words (power of 2, >=2)
//  TX_DEPTH  16  TX buffer words (power of 2, >=2)
// PORTS
//  clk                    in   1            clock
//  rst                    in   1            asynchronous reset, active-high
//  data_rx_packet         in   ID_W+DATA_W  incoming link packet
//  data_rx_valid          in   1            packet valid this cycle
//  data_rx_last           in   1            final packet of message
//  node_id                in   ID_W         this node's ID
//  gpp_rtr_signal         in   1            GPP ready-to-receive: pop one RX word
//  data_rx_complete_flag  out  1            RX message complete, readable
//  RAM_rx_data_out        out  DATA_W       RX word (registered)
//  RAM_rx_data_valid      out  1            RAM_rx_data_out valid this cycle
//  rx_err                 out  1            sticky: RX drop (overflow or busy)
//  gpp_tx_signal          in   1            GPP push of gpp_tx_data
//  gpp_tx_data            in   DATA_W       TX word
//  gpp_tx_last            in   1            final GPP word of message
//  gpp_tx_dest            in   ID_W         destination, sampled with the first push
//  data_tx_ready          in   1            link accepts packet this cycle
//  data_tx_flag           out  1            data_tx_packet valid
//  data_tx_complete_flag  out  1            1-cycle pulse: last packet accepted
//  data_tx_packet         out  ID_W+DATA_W  {dest, word}
//  RAM_tx_data_out        out  DATA_W       word at TX read pointer
//  sp_tx_current          out  $clog2(TX_DEPTH)+1  words left to send
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs IDLE, pointers/counts 0, rx_err 0. Reset mid-message discards it.
//  RX FSM RX_IDLE->RX_FILL->RX_DRAIN->RX_IDLE:
//   - match = data_rx_valid & (dest==node_id). Matching packet in IDLE/FILL: payload written at the edge, count++.
//     IDLE->FILL on the first match.
//   - match & data_rx_last -> DRAIN. data_rx_complete_flag=1 from the next cycle and held through DRAIN.
//   - match while count==RX_DEPTH: dropped, rx_err=1; a dropped last packet still moves the FSM to DRAIN.
//   - match in DRAIN: dropped, rx_err=1.
//   - gpp_rtr_signal in DRAIN with count>0: RAM_rx_data_out=word[rd_ptr] and RAM_rx_data_valid=1 next cycle,
//     count--. Ignored outside DRAIN.
//   - When count reaches 0: next cycle DRAIN->IDLE and flag cleared. Pointers wrap modulo depth.
//  TX FSM TX_IDLE->TX_LOAD->TX_SEND->TX_IDLE:
//   - gpp_tx_signal in IDLE/LOAD writes the word. The first push latches gpp_tx_dest.
//   - Push with gpp_tx_last -> SEND. Push when full: ignored. Push in SEND: ignored.
//   - SEND: data_tx_flag=1, packet={dest,word[rd_ptr]}, held stable until data_tx_ready.
//     Each ready: rd_ptr++, sp_tx_current--.
//   - Final handshake: data_tx_complete_flag pulses the next cycle, flag=0, ->IDLE.
//   - data_tx_ready while data_tx_flag=0: no effect.
//  RX and TX events in the same cycle are fully independent.
// CONFIGURATION
//  DATA_PLANE_BCAST_EN defined: dest=={ID_W{1'b1}} also matches (broadcast), same handling as unicast.
//  Not defined: all-ones dest matches only if node_id is all-ones.
// STRUCTURE
//  data_plane_pkg: rx_state_t, tx_state_t enums; BCAST_ID constant; pkt field-slice functions.
//  Sub-module dp_msg_buffer (params WIDTH, DEPTH): write port, read port, count, full/empty;
//  instantiated once for RX and once for TX.
// TESTING
//  1. rst mid-RX (2 of 4 words) -> all outputs 0; fresh 3-word message later received intact.
//  2. node_id=16'h0005: packets 0x0005_AAAA, 0x0005_BBBB(last), 0x0006_CCCC interleaved
//     -> complete_flag; pops give AAAA, BBBB; CCCC never stored.
//  3. 17 matching packets, RX_DEPTH=16 -> 16 stored, rx_err=1, DRAIN entered on the 17th (last).
//  4. TX 3 words 0x1111..0x3333 dest 0x0009, data_tx_ready low 5 cycles
//     -> packet 0x0009_1111 held, then sent in order; complete pulse 1 cycle.
//  5. Packet 0xFFFF_1234 last: with DATA_PLANE_BCAST_EN -> accepted; without -> ignored.
//  6. RX drain and TX send on the same cycles -> both complete; no cross-corruption.

Source files
------------

// File: rtl/data_plane_pkg.sv
// Shared types and packet helpers for the parametrised data plane.
// Helpers work on a 64-bit container so they serve any ID_W/DATA_W split up to that size.
package data_plane_pkg;

    localparam int unsigned PKT_MAX_W = 64;

    typedef logic [PKT_MAX_W-1:0] pkt_word_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_FILL,
        RX_DRAIN
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SEND
    } tx_state_t;

    // All-ones; callers slice down to their ID width
    localparam pkt_word_t BCAST_ID = '1;

    function automatic pkt_word_t pkt_dest(input pkt_word_t pkt, input int unsigned data_w);
        return pkt >> data_w;
    endfunction

    function automatic pkt_word_t pkt_payload(input pkt_word_t pkt, input int unsigned data_w);
        return pkt & ~(BCAST_ID << data_w);
    endfunction

    function automatic pkt_word_t pkt_pack(input pkt_word_t dest, input pkt_word_t word,
                                           input int unsigned data_w);
        return (dest << data_w) | word;
    endfunction

endpackage

// File: rtl/dp_msg_buffer.sv
// Single-message circular word buffer: one write port, one read port, occupancy count.
// Writes when full and reads when empty are ignored; pointers wrap modulo DEPTH.
module dp_msg_buffer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_wr;
    logic             do_rd;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    // Storage is cleared on reset so the read-pointer word reads as zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/data_plane_param.sv
// Parametrised handshaked data plane between the photonic link and the GPP (independent RX/TX).
// Define DATA_PLANE_BCAST_EN to also accept packets addressed to the all-ones broadcast ID.
module data_plane_param
    import data_plane_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ID_W     = 16,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ID_W+DATA_W-1:0]      data_rx_packet,
    input  logic                        data_rx_valid,
    input  logic                        data_rx_last,
    input  logic [ID_W-1:0]             node_id,
    input  logic                        gpp_rtr_signal,
    output logic                        data_rx_complete_flag,
    output logic [DATA_W-1:0]           RAM_rx_data_out,
    output logic                        RAM_rx_data_valid,
    output logic                        rx_err,
    input  logic                        gpp_tx_signal,
    input  logic [DATA_W-1:0]           gpp_tx_data,
    input  logic                        gpp_tx_last,
    input  logic [ID_W-1:0]             gpp_tx_dest,
    input  logic                        data_tx_ready,
    output logic                        data_tx_flag,
    output logic                        data_tx_complete_flag,
    output logic [ID_W+DATA_W-1:0]      data_tx_packet,
    output logic [DATA_W-1:0]           RAM_tx_data_out,
    output logic [$clog2(TX_DEPTH):0]   sp_tx_current
);

    localparam int unsigned PKT_W = ID_W + DATA_W;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

    rx_state_t rx_state, rx_state_nxt;
    tx_state_t tx_state, tx_state_nxt;

    pkt_word_t         rx_pkt_ext, rx_dest_ext, rx_pay_ext, tx_pkt_ext;
    logic [ID_W-1:0]   rx_dest;
    logic [DATA_W-1:0] rx_payload;
    logic              rx_hit, rx_match, rx_wr, rx_rd, rx_drop;
    logic              rx_full, rx_empty;
    logic [RX_CW-1:0]  rx_count;
    logic [DATA_W-1:0] rx_rd_data;

    logic              tx_push, tx_hs, tx_last_hs;
    logic              tx_full, tx_empty;
    logic [TX_CW-1:0]  tx_count;
    logic [DATA_W-1:0] tx_rd_data;
    logic [ID_W-1:0]   tx_dest_q;
    logic              tx_done_q;
    logic              unused_pkt_bits;

    // Packet field extraction through the package helpers
    assign rx_pkt_ext  = pkt_word_t'(data_rx_packet);
    assign rx_dest_ext = pkt_dest(rx_pkt_ext, DATA_W);
    assign rx_pay_ext  = pkt_payload(rx_pkt_ext, DATA_W);
    assign rx_dest     = rx_dest_ext[ID_W-1:0];
    assign rx_payload  = rx_pay_ext[DATA_W-1:0];
    assign tx_pkt_ext  = pkt_pack(pkt_word_t'(tx_dest_q), pkt_word_t'(tx_rd_data), DATA_W);
    assign unused_pkt_bits = ^{rx_dest_ext[PKT_MAX_W-1:ID_W], rx_pay_ext[PKT_MAX_W-1:DATA_W],
                               tx_pkt_ext[PKT_MAX_W-1:PKT_W]};

`ifdef DATA_PLANE_BCAST_EN
    assign rx_hit = (rx_dest == node_id) || (rx_dest == BCAST_ID[ID_W-1:0]);
`else
    assign rx_hit = (rx_dest == node_id);
`endif

    // ---------------- RX path ----------------
    assign rx_match = data_rx_valid && rx_hit;
    assign rx_wr    = rx_match && (rx_state != RX_DRAIN);
    assign rx_drop  = rx_match && ((rx_state == RX_DRAIN) || rx_full);
    assign rx_rd    = (rx_state == RX_DRAIN) && gpp_rtr_signal && !rx_empty;

    dp_msg_buffer #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_wr),
        .wr_data (rx_payload),
        .rd_en   (rx_rd),
        .rd_data (rx_rd_data),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    // A last packet dropped for overflow still closes the message
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_match) rx_state_nxt = data_rx_last ? RX_DRAIN : RX_FILL;
            RX_FILL:  if (rx_match && data_rx_last) rx_state_nxt = RX_DRAIN;
            RX_DRAIN: if (rx_empty) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        data_rx_complete_flag = (rx_state == RX_DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RAM_rx_data_out   <= '0;
            RAM_rx_data_valid <= 1'b0;
            rx_err            <= 1'b0;
        end else begin
            RAM_rx_data_valid <= rx_rd;
            if (rx_rd) begin
                RAM_rx_data_out <= rx_rd_data;
            end
            if (rx_drop) begin
                rx_err <= 1'b1;
            end
        end
    end

    // ---------------- TX path ----------------
    assign tx_push    = gpp_tx_signal && (tx_state != TX_SEND) && !tx_full;
    assign tx_hs      = (tx_state == TX_SEND) && data_tx_ready;
    assign tx_last_hs = tx_hs && (tx_count == TX_CW'(1));

    dp_msg_buffer #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_push),
        .wr_data (gpp_tx_data),
        .rd_en   (tx_hs),
        .rd_data (tx_rd_data),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_push) tx_state_nxt = gpp_tx_last ? TX_SEND : TX_LOAD;
            TX_LOAD: if (tx_push && gpp_tx_last) tx_state_nxt = TX_SEND;
            TX_SEND: if (tx_last_hs || tx_empty) tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        data_tx_flag          = (tx_state == TX_SEND);
        data_tx_complete_flag = tx_done_q;
        data_tx_packet        = data_tx_flag ? tx_pkt_ext[PKT_W-1:0] : '0;
        RAM_tx_data_out       = tx_rd_data;
        sp_tx_current         = tx_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_dest_q <= '0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= tx_last_hs;
            if ((tx_state == TX_IDLE) && tx_push) begin
                tx_dest_q <= gpp_tx_dest;
            end
        end
    end

endmodule

// File: tb/tb_data_plane_param.sv
// Scoreboard bench for data_plane_param: expected RX words / TX packets are queued when driven
// and compared when the DUT delivers them.
module tb_data_plane_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_rx_packet = '0;
    logic        data_rx_valid = 1'b0;
    logic        data_rx_last = 1'b0;
    logic [15:0] node_id = 16'h0005;
    logic        gpp_rtr_signal = 1'b0;
    logic        data_rx_complete_flag;
    logic [15:0] RAM_rx_data_out;
    logic        RAM_rx_data_valid;
    logic        rx_err;
    logic        gpp_tx_signal = 1'b0;
    logic [15:0] gpp_tx_data = '0;
    logic        gpp_tx_last = 1'b0;
    logic [15:0] gpp_tx_dest = '0;
    logic        data_tx_ready = 1'b0;
    logic        data_tx_flag;
    logic        data_tx_complete_flag;
    logic [31:0] data_tx_packet;
    logic [15:0] RAM_tx_data_out;
    logic [4:0]  sp_tx_current;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] rx_exp[$];
    logic [31:0] tx_exp[$];

    data_plane_param #(
        .DATA_W   (16),
        .ID_W     (16),
        .RX_DEPTH (16),
        .TX_DEPTH (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_rx_packet        (data_rx_packet),
        .data_rx_valid         (data_rx_valid),
        .data_rx_last          (data_rx_last),
        .node_id               (node_id),
        .gpp_rtr_signal        (gpp_rtr_signal),
        .data_rx_complete_flag (data_rx_complete_flag),
        .RAM_rx_data_out       (RAM_rx_data_out),
        .RAM_rx_data_valid     (RAM_rx_data_valid),
        .rx_err                (rx_err),
        .gpp_tx_signal         (gpp_tx_signal),
        .gpp_tx_data           (gpp_tx_data),
        .gpp_tx_last           (gpp_tx_last),
        .gpp_tx_dest           (gpp_tx_dest),
        .data_tx_ready         (data_tx_ready),
        .data_tx_flag          (data_tx_flag),
        .data_tx_complete_flag (data_tx_complete_flag),
        .data_tx_packet        (data_tx_packet),
        .RAM_tx_data_out       (RAM_tx_data_out),
        .sp_tx_current         (sp_tx_current)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #12;
        rst = 1'b0;
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_complete"}, 64'(data_rx_complete_flag), 64'd0);
        check({tag, "_rx_data"},     64'(RAM_rx_data_out),       64'd0);
        check({tag, "_rx_valid"},    64'(RAM_rx_data_valid),     64'd0);
        check({tag, "_rx_err"},      64'(rx_err),                64'd0);
        check({tag, "_tx_flag"},     64'(data_tx_flag),          64'd0);
        check({tag, "_tx_complete"}, 64'(data_tx_complete_flag), 64'd0);
        check({tag, "_tx_packet"},   64'(data_tx_packet),        64'd0);
        check({tag, "_tx_ram"},      64'(RAM_tx_data_out),       64'd0);
        check({tag, "_sp_tx"},       64'(sp_tx_current),         64'd0);
    endtask

    task automatic rx_pkt(input logic [15:0] dest, input logic [15:0] payload,
                          input logic last, input logic stored);
        data_rx_packet = {dest, payload};
        data_rx_valid  = 1'b1;
        data_rx_last   = last;
        if (stored) rx_exp.push_back(payload);
        step();
        data_rx_valid  = 1'b0;
        data_rx_last   = 1'b0;
    endtask

    task automatic rx_drain(input int unsigned n);
        gpp_rtr_signal = 1'b1;
        repeat (n) step();
        gpp_rtr_signal = 1'b0;
    endtask

    task automatic tx_push(input logic [15:0] dest, input logic [15:0] word, input logic last);
        gpp_tx_signal = 1'b1;
        gpp_tx_dest   = dest;
        gpp_tx_data   = word;
        gpp_tx_last   = last;
        step();
        gpp_tx_signal = 1'b0;
        gpp_tx_last   = 1'b0;
    endtask

    // Scoreboard side: outputs sampled mid-cycle, handshakes judged before the edge that takes them
    always @(negedge clk) begin
        if (!rst) begin
            if (RAM_rx_data_valid) begin
                check("rx_word_expected", 64'(rx_exp.size() != 0), 64'd1);
                if (rx_exp.size() != 0) check("rx_word", 64'(RAM_rx_data_out), 64'(rx_exp.pop_front()));
            end
            if (data_tx_flag && data_tx_ready) begin
                check("tx_pkt_expected", 64'(tx_exp.size() != 0), 64'd1);
                if (tx_exp.size() != 0) check("tx_pkt", 64'(data_tx_packet), 64'(tx_exp.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check_idle_outputs("reset");

        // 1: reset partway through a message, then a clean 3-word message
        rx_pkt(16'h0005, 16'h0101, 1'b0, 1'b0);
        rx_pkt(16'h0005, 16'h0202, 1'b0, 1'b0);
        check("t1_no_complete_mid", 64'(data_rx_complete_flag), 64'd0);
        do_reset();
        check_idle_outputs("t1_rst");
        for (int i = 0; i < 3; i++) rx_pkt(16'h0005, 16'h0301 + 16'(i), 1'(i == 2), 1'b1);
        check("t1_complete", 64'(data_rx_complete_flag), 64'd1);
        rx_drain(3);
        check("t1_complete_held_at_zero", 64'(data_rx_complete_flag), 64'd1);
        step();
        check("t1_complete_clear", 64'(data_rx_complete_flag), 64'd0);

        // 2: address filtering and drop while draining
        rx_pkt(16'h0005, 16'hAAAA, 1'b0, 1'b1);
        rx_pkt(16'h0006, 16'hCCCC, 1'b0, 1'b0);
        rx_pkt(16'h0005, 16'hBBBB, 1'b1, 1'b1);
        check("t2_complete", 64'(data_rx_complete_flag), 64'd1);
        check("t2_no_err", 64'(rx_err), 64'd0);
        rx_pkt(16'h0005, 16'hDDDD, 1'b0, 1'b0);
        check("t2_err_drain_drop", 64'(rx_err), 64'd1);
        rx_drain(2);
        step();
        check("t2_complete_clear", 64'(data_rx_complete_flag), 64'd0);
        do_reset();

        // 3: overflow, last packet dropped but still closes the message
        for (int i = 0; i < 17; i++) begin
            rx_pkt(16'h0005, 16'h1000 + 16'(i), 1'(i == 16), 1'(i < 16));
            if (i == 15) begin
                check("t3_not_complete_at_16", 64'(data_rx_complete_flag), 64'd0);
                check("t3_no_err_at_16", 64'(rx_err), 64'd0);
            end
        end
        check("t3_complete", 64'(data_rx_complete_flag), 64'd1);
        check("t3_err", 64'(rx_err), 64'd1);
        rx_drain(16);
        step();
        check("t3_complete_clear", 64'(data_rx_complete_flag), 64'd0);
        do_reset();

        // 4: TX with backpressure; later pushes carry a different dest that must be ignored
        tx_push(16'h0009, 16'h1111, 1'b0);
        check("t4_not_sending", 64'(data_tx_flag), 64'd0);
        tx_push(16'hBEEF, 16'h2222, 1'b0);
        tx_push(16'hBEEF, 16'h3333, 1'b1);
        for (int i = 0; i < 3; i++) tx_exp.push_back({16'h0009, 16'h1111 * 16'(i + 1)});
        check("t4_sp_loaded", 64'(sp_tx_current), 64'd3);
        for (int i = 0; i < 5; i++) begin
            check("t4_flag_hold", 64'(data_tx_flag), 64'd1);
            check("t4_pkt_hold", 64'(data_tx_packet), 64'h0009_1111);
            gpp_tx_signal = (i == 2);
            gpp_tx_data   = 16'h7777;
            step();
            gpp_tx_signal = 1'b0;
        end
        check("t4_sp_after_push_in_send", 64'(sp_tx_current), 64'd3);
        data_tx_ready = 1'b1;
        step();
        check("t4_sp_after_first", 64'(sp_tx_current), 64'd2);
        step();
        step();
        check("t4_complete_pulse", 64'(data_tx_complete_flag), 64'd1);
        check("t4_flag_clear", 64'(data_tx_flag), 64'd0);
        check("t4_sp_zero", 64'(sp_tx_current), 64'd0);
        step();
        data_tx_ready = 1'b0;
        check("t4_complete_one_cycle", 64'(data_tx_complete_flag), 64'd0);

        // 5: all-ones destination
`ifdef DATA_PLANE_BCAST_EN
        rx_pkt(16'hFFFF, 16'h1234, 1'b1, 1'b1);
        check("t5_bcast_complete", 64'(data_rx_complete_flag), 64'd1);
        rx_drain(1);
        step();
        check("t5_bcast_clear", 64'(data_rx_complete_flag), 64'd0);
`else
        rx_pkt(16'hFFFF, 16'h1234, 1'b1, 1'b0);
        check("t5_bcast_ignored", 64'(data_rx_complete_flag), 64'd0);
        check("t5_bcast_no_err", 64'(rx_err), 64'd0);
`endif

        // 6: RX and TX loaded and emptied on the same cycles
        for (int i = 0; i < 4; i++) begin
            data_rx_packet = {16'h0005, 16'h00A0 + 16'(i)};
            data_rx_valid  = 1'b1;
            data_rx_last   = (i == 3);
            gpp_tx_signal  = 1'b1;
            gpp_tx_data    = 16'h00B0 + 16'(i);
            gpp_tx_dest    = 16'h0042;
            gpp_tx_last    = (i == 3);
            rx_exp.push_back(16'h00A0 + 16'(i));
            tx_exp.push_back({16'h0042, 16'h00B0 + 16'(i)});
            step();
        end
        data_rx_valid = 1'b0;
        data_rx_last  = 1'b0;
        gpp_tx_signal = 1'b0;
        gpp_tx_last   = 1'b0;
        check("t6_rx_complete", 64'(data_rx_complete_flag), 64'd1);
        check("t6_tx_flag", 64'(data_tx_flag), 64'd1);
        check("t6_sp", 64'(sp_tx_current), 64'd4);
        gpp_rtr_signal = 1'b1;
        data_tx_ready  = 1'b1;
        repeat (4) step();
        gpp_rtr_signal = 1'b0;
        data_tx_ready  = 1'b0;
        check("t6_tx_complete", 64'(data_tx_complete_flag), 64'd1);
        check("t6_rx_still_complete", 64'(data_rx_complete_flag), 64'd1);
        step();
        check("t6_rx_clear", 64'(data_rx_complete_flag), 64'd0);
        check("t6_tx_complete_clear", 64'(data_tx_complete_flag), 64'd0);
        check("t6_rx_err", 64'(rx_err), 64'd0);

        repeat (2) step();
        check("rx_scoreboard_empty", 64'(rx_exp.size()), 64'd0);
        check("tx_scoreboard_empty", 64'(tx_exp.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
